// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core: Fetch/Decode/Execute/Memory/Writeback.
// Optional build macro MAIN_FSM_ADDI_ONLY_EN gates EXECI aluOp on the decoded opcode.
module multicycle_main_fsm #(
    parameter int OPW = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    output logic           pcWrite,
    output logic           adrSrc,
    output logic           memWrite,
    output logic           irWrite,
    output logic [1:0]     resultSrc,
    output logic [1:0]     aluSrcA,
    output logic [1:0]     aluSrcB,
    output logic [1:0]     aluOp,
    output logic           regWrite,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [OPW-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPW-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPW-1:0] OP_R   = 7'b0110011;
    localparam logic [OPW-1:0] OP_I   = 7'b0010011;
    localparam logic [OPW-1:0] OP_JAL = 7'b1101111;
    localparam logic [OPW-1:0] OP_BEQ = 7'b1100011;

    state_t state_q;
    state_t state_d;
    state_t dec_state;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MAIN_FSM_ADDI_ONLY_EN
    logic [OPW-1:0] op_q;

    // Opcode seen in DECODE, used to detect op changing mid-instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
        end else if (state_q == DECODE) begin
            op_q <= op;
        end
    end
`endif

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_d = MEMADR;
                end else if (op == OP_R) begin
                    state_d = EXECR;
                end else if (op == OP_I) begin
                    state_d = EXECI;
                end else if (op == OP_JAL) begin
                    state_d = JAL;
                end else if (op == OP_BEQ) begin
                    state_d = BEQ;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            JAL:      state_d = ALUWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // During reset the selects present FETCH values whatever the current state.
    assign dec_state = reset ? FETCH : state_q;

    always_comb begin
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        regWrite  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (dec_state)
            FETCH: begin
                irWrite   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                pc_update = 1'b1;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            EXECR: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
            end
            EXECI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
`ifdef MAIN_FSM_ADDI_ONLY_EN
                aluOp   = (op == OP_I && op == op_q) ? 2'b10 : 2'b00;
`else
                aluOp   = 2'b10;
`endif
            end
            ALUWB: begin
                regWrite = 1'b1;
            end
            JAL: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b01;
                branch  = 1'b1;
            end
            default: begin
                pc_update = 1'b0;
            end
        endcase
        if (reset) begin
            irWrite   = 1'b0;
            regWrite  = 1'b0;
            memWrite  = 1'b0;
            pc_update = 1'b0;
            branch    = 1'b0;
        end
    end

    assign pcWrite = pc_update | (branch & zero);
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: per-instruction state walks and strobes.
// Each task starts and ends in FETCH.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regWrite;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_main_fsm #(.OPW(7)) dut (
        .clk(clk),
        .reset(reset),
        .op(op),
        .zero(zero),
        .pcWrite(pcWrite),
        .adrSrc(adrSrc),
        .memWrite(memWrite),
        .irWrite(irWrite),
        .resultSrc(resultSrc),
        .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB),
        .aluOp(aluOp),
        .regWrite(regWrite),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op    = 7'b0110011;
        zero  = 1'b0;
        step();
        step();
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got %0d want 0", state);
        end
        n_tests++;
        if ({pcWrite, irWrite, regWrite, memWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes got %b want 0000",
                     {pcWrite, irWrite, regWrite, memWrite});
        end
        n_tests++;
        if (aluSrcB !== 2'b10 || resultSrc !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_selects got B=%b R=%b want 10 10",
                     aluSrcB, resultSrc);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd0 || pcWrite !== 1'b1 || irWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL release_fetch got s=%0d pc=%b ir=%b want 0 1 1",
                     state, pcWrite, irWrite);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = 7'b0000011;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (state !== exp[i]) begin
                n_fail++;
                $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            n_tests++;
            if (memWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL lw_memwrite[%0d] got %b want 0", i, memWrite);
            end
            if (i == 3) begin
                n_tests++;
                if (adrSrc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lw_adrsrc got %b want 1", adrSrc);
                end
            end
            if (i == 4) begin
                n_tests++;
                if (regWrite !== 1'b1 || resultSrc !== 2'b01) begin
                    n_fail++;
                    $display("FAIL lw_wb got rw=%b rs=%b want 1 01",
                             regWrite, resultSrc);
                end
            end
            step();
        end
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL lw_end got %0d want 0", state);
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        op = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (state !== exp[i]) begin
                n_fail++;
                $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            n_tests++;
            if (memWrite !== (i == 3) || regWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL sw_strobes[%0d] got mw=%b rw=%b want %b 0",
                         i, memWrite, regWrite, (i == 3));
            end
            if (i == 3) begin
                n_tests++;
                if (adrSrc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sw_adrsrc got %b want 1", adrSrc);
                end
            end
            step();
        end
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL sw_end got %0d want 0", state);
        end
    endtask

    task automatic test_rtype();
        logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        op = 7'b0110011;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (state !== exp[i]) begin
                n_fail++;
                $display("FAIL r_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            n_tests++;
            if (regWrite !== (i == 3)) begin
                n_fail++;
                $display("FAIL r_regwrite[%0d] got %b want %b", i, regWrite, (i == 3));
            end
            if (i == 2) begin
                n_tests++;
                if (aluOp !== 2'b10 || aluSrcA !== 2'b10 || aluSrcB !== 2'b00) begin
                    n_fail++;
                    $display("FAIL r_exec got op=%b a=%b b=%b want 10 10 00",
                             aluOp, aluSrcA, aluSrcB);
                end
                // op changes outside DECODE/MEMADR must be ignored
                op = 7'b0000011;
            end
            step();
        end
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL r_end got %0d want 0", state);
        end
    endtask

    task automatic test_itype();
        logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd8, 4'd7};
        op = 7'b0010011;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (state !== exp[i]) begin
                n_fail++;
                $display("FAIL i_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            if (i == 2) begin
                n_tests++;
                if (aluOp !== 2'b10 || aluSrcB !== 2'b01) begin
                    n_fail++;
                    $display("FAIL i_exec got op=%b b=%b want 10 01", aluOp, aluSrcB);
                end
                op = 7'b0110011;
                #1;
                n_tests++;
`ifdef MAIN_FSM_ADDI_ONLY_EN
                if (aluOp !== 2'b00) begin
                    n_fail++;
                    $display("FAIL i_glitch got %b want 00", aluOp);
                end
`else
                if (aluOp !== 2'b10) begin
                    n_fail++;
                    $display("FAIL i_glitch got %b want 10", aluOp);
                end
`endif
            end
            step();
        end
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL i_end got %0d want 0", state);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0] exp [3] = '{4'd0, 4'd1, 4'd10};
        op   = 7'b1100011;
        zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) zero = z;
            #1;
            n_tests++;
            if (state !== exp[i]) begin
                n_fail++;
                $display("FAIL beq%0b_state[%0d] got %0d want %0d", z, i, state, exp[i]);
            end
            n_tests++;
            if (pcWrite !== (i == 0 || (i == 2 && z))) begin
                n_fail++;
                $display("FAIL beq%0b_pcwrite[%0d] got %b want %b",
                         z, i, pcWrite, (i == 0 || (i == 2 && z)));
            end
            if (i == 2) begin
                n_tests++;
                if (aluOp !== 2'b01 || regWrite !== 1'b0) begin
                    n_fail++;
                    $display("FAIL beq%0b_exec got op=%b rw=%b want 01 0",
                             z, aluOp, regWrite);
                end
            end
            step();
        end
        zero = 1'b0;
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL beq%0b_end got %0d want 0", z, state);
        end
    endtask

    task automatic test_illegal();
        op = 7'b1111111;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (state !== 4'(i) || regWrite !== 1'b0 || memWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL ill_cyc[%0d] got s=%0d rw=%b mw=%b want %0d 0 0",
                         i, state, regWrite, memWrite, i);
            end
            step();
        end
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL ill_end got %0d want 0", state);
        end
    endtask

    task automatic test_jal_reset();
        logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd9, 4'd7};
        op = 7'b1101111;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (state !== exp[i]) begin
                n_fail++;
                $display("FAIL jal_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            if (i == 2) begin
                n_tests++;
                if (pcWrite !== 1'b1 || aluSrcA !== 2'b01 || aluSrcB !== 2'b10) begin
                    n_fail++;
                    $display("FAIL jal_exec got pc=%b a=%b b=%b want 1 01 10",
                             pcWrite, aluSrcA, aluSrcB);
                end
            end
            step();
        end
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL jal_end got %0d want 0", state);
        end
        step();
        step();
        n_tests++;
        if (state !== 4'd9) begin
            n_fail++;
            $display("FAIL jal2_state got %0d want 9", state);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (pcWrite !== 1'b0 || regWrite !== 1'b0 || aluSrcB !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid got pc=%b rw=%b b=%b want 0 0 10",
                     pcWrite, regWrite, aluSrcB);
        end
        step();
        n_tests++;
        if (state !== 4'd0 || regWrite !== 1'b0 || irWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after got s=%0d rw=%b ir=%b want 0 0 0",
                     state, regWrite, irWrite);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (irWrite !== 1'b1 || pcWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release got ir=%b pc=%b want 1 1", irWrite, pcWrite);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_itype();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        test_jal_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
